imem_loader: RTL
================

Name: imem_loader

Overview:
Boot-time writer for the instruction memory, which the core otherwise only reads. It accepts a byte stream over a valid/ready interface (typically from a UART receiver) and packs it into little-endian 32-bit words. It writes those words sequentially into the instruction memory write port, verifies an XOR checksum, and holds the core in reset until a good image is loaded.

Parameters:
ADDR_WIDTH, 8, instruction memory depth in words is 2^ADDR_WIDTH
BASE_ADDR, 32'h0000_0000, byte address of the first word written
TIMEOUT_CYCLES, 1000000, idle cycles allowed between accepted bytes before abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset; 0 = in reset
start  in  1  single-cycle pulse that begins a load; ignored while busy=1
rx_data  in  8  stream byte
rx_valid  in  1  rx_data is valid
rx_ready  out  1  loader can accept a byte this cycle
imem_we  out  1  instruction memory write strobe
imem_waddr  out  32  byte address of the write, word-aligned
imem_wdata  out  32  write word
cpu_hold  out  1  holds the core in reset while 1
busy  out  1  load in progress
done  out  1  last load completed with a good checksum (level)
error  out  1  last load aborted or failed (level)
words_loaded  out  ADDR_WIDTH+1  words written in the current/last load

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; rx_ready, imem_we, cpu_hold, busy, done, error = 0; imem_waddr, imem_wdata, words_loaded, checksum, timeout counter = 0. A partially assembled word is discarded.
- Stream format: N_lo, N_hi (16-bit word count N), then 4N payload bytes (LSB first per word), then 1 check byte equal to the XOR of all payload bytes.
- A byte is accepted when rx_valid && rx_ready in the same cycle.
- States:
  - IDLE: start -> HDR_LO. In the same edge: cpu_hold=1, busy=1, done=0, error=0, words_loaded=0, checksum=0.
  - HDR_LO: accept byte -> HDR_HI.
  - HDR_HI: accept byte. If N > 2^ADDR_WIDTH -> ERR with no writes. If N = 0 -> CHECK. Otherwise -> PAYLOAD.
  - PAYLOAD: accept bytes into the packer and XOR each into checksum. When the 4th byte of a word is accepted -> WRITE.
  - WRITE: one cycle. rx_ready=0, imem_we=1, imem_waddr = BASE_ADDR + 4*words_loaded, imem_wdata = assembled word. words_loaded increments at the end of this cycle. -> CHECK if words_loaded+1 = N, else -> PAYLOAD.
  - CHECK: accept byte. If it equals checksum -> DONE, else -> ERR.
  - DONE: done=1, busy=0, cpu_hold=0. start -> HDR_LO.
  - ERR: error=1, busy=0, cpu_hold stays 1 so a partial image never runs. start -> HDR_LO.
- rx_ready=1 only in HDR_LO, HDR_HI, PAYLOAD, CHECK. It is a registered function of state, with no combinational path from rx_valid.
- imem_we is never asserted for a partial word. Byte-to-write latency is one cycle after acceptance of the 4th byte.
- Timeout: the counter clears on every accepted byte and on entry to HDR_LO. It increments in any rx_ready=1 state. When it reaches TIMEOUT_CYCLES -> ERR.
- start while busy is ignored. start and a byte on the same cycle in IDLE: only start takes effect, and the byte is not accepted.
- Address wrap is impossible by construction because of the N limit. words_loaded holds its value after DONE/ERR.

Decomposition:
- Shared package: state enumeration, header/check byte constants, WORD_BYTES=4.
- Sub-module imem_word_packer: 2-bit byte index, 32-bit shift/assembly register, word_ready pulse, clear input.
- FSM, checksum and timeout counter stay in imem_loader.

Test Plan:
1. N=2, bytes 02 00 93 00 50 00 13 01 A0 00 71 -> writes (0x0, 0x00500093) then (0x4, 0x00A00113); done=1, cpu_hold=0, words_loaded=2.
2. Same stream with check byte 0x70 -> both writes occur; error=1, done=0, cpu_hold=1.
3. N=0, bytes 00 00 00 -> done=1, imem_we never asserted, words_loaded=0.
4. ADDR_WIDTH=8, header 01 01 (N=257) -> error=1 right after the header byte, no writes, rx_ready=0.
5. TIMEOUT_CYCLES=16, N=1, send only 3 payload bytes -> error=1 exactly 16 cycles after the last acceptance; no write occurs.
6. Drop reset to 0 mid-payload with rx_valid held high -> all outputs go to reset values without waiting for clk. After release, a fresh start with scenario 1's stream completes correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_PAYLOAD,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam logic [7:0] CHECK_INIT = 8'h00;

endpackage

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - packs LSB-first bytes into little-endian 32-bit words
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0] idx;

  // Shifting right means the first byte of a word ends up in bits [7:0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx  <= '0;
      word <= '0;
    end else if (clear) begin
      idx  <= '0;
      word <= '0;
    end else if (byte_valid) begin
      word <= {byte_data, word[31:8]};
      idx  <= idx + 2'd1;
    end
  end

  assign word_ready = byte_valid && (idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte stream to instruction memory writer with XOR check
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [31:0]           imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  state_t              state;
  logic [7:0]          n_lo;
  logic [15:0]         n_words;
  logic [7:0]          checksum;
  logic [TW-1:0]       tmo;
  logic                accept;
  logic                pk_valid;
  logic                pk_clear;
  logic                pk_word_ready;
  logic [15:0]         hdr_n;
  logic [ADDR_WIDTH:0] wl_next;

  assign accept   = rx_valid && rx_ready;
  assign pk_valid = accept && (state == ST_PAYLOAD);
  assign pk_clear = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign hdr_n    = {rx_data, n_lo};
  assign wl_next  = words_loaded + 1'b1;

  // The packer's register is the write data; it is complete during ST_WRITE.
  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (rx_data),
    .word       (imem_wdata),
    .word_ready (pk_word_ready)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      checksum     <= CHECK_INIT;
      tmo          <= '0;
      n_lo         <= '0;
      n_words      <= '0;
    end else begin
      imem_we <= 1'b0;

      // Timeout only runs while waiting for a byte; transitions below need an accept.
      if (accept) begin
        tmo <= '0;
      end else if (rx_ready) begin
        if (tmo == TMO_LAST) begin
          state    <= ST_ERR;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
          error    <= 1'b1;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end

      unique case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_HDR_LO;
            rx_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            checksum     <= CHECK_INIT;
            tmo          <= '0;
          end
        end
        ST_HDR_LO: begin
          if (accept) begin
            n_lo  <= rx_data;
            state <= ST_HDR_HI;
          end
        end
        ST_HDR_HI: begin
          if (accept) begin
            n_words <= hdr_n;
            if ({1'b0, hdr_n} > MAX_WORDS) begin
              state    <= ST_ERR;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else if (hdr_n == 16'd0) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            checksum <= checksum ^ rx_data;
            if (pk_word_ready) begin
              state      <= ST_WRITE;
              rx_ready   <= 1'b0;
              imem_we    <= 1'b1;
              imem_waddr <= BASE_ADDR + 32'({words_loaded, 2'b00});
            end
          end
        end
        ST_WRITE: begin
          words_loaded <= wl_next;
          rx_ready     <= 1'b1;
          state        <= (17'(wl_next) == {1'b0, n_words}) ? ST_CHECK : ST_PAYLOAD;
        end
        ST_CHECK: begin
          if (accept) begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            if (rx_data == checksum) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
